rebalance_scheduler: RTL
========================

// Module: rebalance_scheduler
// PURPOSE
//  Top-level sequencer for one portfolio rebalance: covariance update -> eigen solve -> eigenportfolio.
//  Starts each stage with a 1-cycle start pulse and waits for that stage's done.
//  Triggers a rebalance every PERIOD cycles, or on request. Stalled stages are aborted by a watchdog.
//  Publishes the final weight vector as a registered snapshot, together with a valid pulse.
// PARAMETERS
//  WIDTH     16    bit width of each portfolio weight (signed fixed point)
//  N_STOCKS  3     number of stocks / weights
//  PERIOD    1024  cycles between automatic rebalances (>=2)
//  TIMEOUT   4096  maximum cycles allowed per stage before abort (>=2)
// PORTS
//  clk             in   1                 clock
//  rst             in   1                 reset, synchronous, active-high
//  enable          in   1                 allow automatic periodic rebalance
//  force_rebal     in   1                 1-cycle request for an immediate rebalance
//  cov_start       out  1                 start pulse, covariance stage
//  cov_done        in   1                 covariance stage complete
//  eig_start       out  1                 start pulse, eigen solver
//  eig_done        in   1                 eigen solver complete
//  port_start      out  1                 start pulse, eigenportfolio stage
//  port_done       in   1                 eigenportfolio stage complete
//  port_weights    in   N_STOCKS*WIDTH    signed weights from the eigenportfolio stage
//  weights         out  N_STOCKS*WIDTH    last successfully published weights
//  weights_valid   out  1                 1-cycle pulse when weights update
//  busy            out  1                 high in any state other than IDLE
//  timeout_err     out  1                 sticky: last run was aborted
//  stage           out  3                 current state encoding
// BEHAVIOUR
//  States and encodings: IDLE=0, COV=1, EIG=2, PORT=3, LATCH=4.
//  Reset values: all outputs 0, state IDLE, both counters 0, pending flag 0.
//  Reset is honoured in any state, including mid-run. No start pulse is issued in the cycle after reset.
//  Period counter (ceil(log2 PERIOD) bits):
//   - Increments in IDLE while enable=1.
//   - Clears while enable=0, outside IDLE, and on launch.
//  Launch from IDLE (IDLE->COV) happens when any of these holds:
//   - period counter == PERIOD-1
//   - force_rebal=1
//   - pending=1
//  Pending flag: set when force_rebal=1 outside IDLE; cleared on launch. Multiple requests merge into one.
//  Stage start pulses:
//   - Each xxx_start is high exactly one cycle: the first cycle in its state.
//   - No registered lag: xxx_start is high in the cycle where stage==that state for the first time.
//  Stage done sampling:
//   - xxx_done is honoured only in the matching state, and only after the start cycle.
//   - A done arriving in the start cycle or in any other state is ignored.
//  Transitions: COV -done-> EIG; EIG -done-> PORT; PORT -done-> LATCH.
//   - The PORT->LATCH step captures port_weights into weights on the port_done clock edge.
//  LATCH state (one cycle):
//   - weights_valid=1 and timeout_err cleared.
//   - Next state is IDLE.
//  Watchdog:
//   - Clears on every stage entry and increments each cycle in COV/EIG/PORT.
//   - If it reaches TIMEOUT-1 without the matching done: go to IDLE, set timeout_err=1.
//   - weights keep their old value; no weights_valid pulse.
//   - If done and timeout occur in the same cycle, done wins.
//  enable dropped mid-run: the current run completes normally. It only gates automatic launches.
//  busy = (state != IDLE). Weights are passed through unaltered; no arithmetic on port_weights.
//  Minimum run (each done one cycle after its start): 7 cycles from leaving IDLE to weights_valid.
// TESTING
//  1. PERIOD=8, enable=1 from reset, dones 1 cycle after each start.
//     -> cov_start at cycle 8; weights_valid at cycle 14; weights = port_weights {16'h1000,16'h2000,16'hD000}.
//  2. force_rebal pulsed in IDLE with enable=0.
//     -> cov_start the next cycle; period counter stays 0.
//  3. eig_done never arrives, TIMEOUT=16.
//     -> abort 15 cycles after eig_start; timeout_err=1; weights unchanged; no weights_valid.
//     -> the next successful run clears timeout_err in LATCH.
//  4. force_rebal twice during EIG.
//     -> exactly one extra run launches in the cycle after LATCH->IDLE.
//  5. cov_done asserted in the cov_start cycle and port_done asserted during EIG.
//     -> both ignored; FSM stays until a correctly timed done.
//  6. rst asserted during PORT.
//     -> next cycle all outputs 0, stage=0; a stray port_done afterwards has no effect.

Source files
------------

// File: rtl/rebalance_scheduler.sv
// Rebalance sequencer: covariance update -> eigen solve -> eigenportfolio,
// launched periodically or on request, with a per-stage watchdog and a
// registered snapshot of the final weights.
//
//   state | meaning
//   ------+---------------------------------------------------------
//   IDLE  | waiting for period expiry, force_rebal or a pending request
//   COV   | covariance stage running (cov_start on first cycle)
//   EIG   | eigen solver running (eig_start on first cycle)
//   PORT  | eigenportfolio stage running (port_start on first cycle)
//   LATCH | one cycle: weights_valid pulse, timeout_err already cleared
module rebalance_scheduler #(
  parameter int WIDTH    = 16,
  parameter int N_STOCKS = 3,
  parameter int PERIOD   = 1024,
  parameter int TIMEOUT  = 4096
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      force_rebal,
  output logic                      cov_start,
  input  logic                      cov_done,
  output logic                      eig_start,
  input  logic                      eig_done,
  output logic                      port_start,
  input  logic                      port_done,
  input  logic [N_STOCKS*WIDTH-1:0] port_weights,
  output logic [N_STOCKS*WIDTH-1:0] weights,
  output logic                      weights_valid,
  output logic                      busy,
  output logic                      timeout_err,
  output logic [2:0]                stage
);

  localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    COV   = 3'd1,
    EIG   = 3'd2,
    PORT  = 3'd3,
    LATCH = 3'd4
  } state_t;

  state_t        state, state_n;
  logic          first;       // high in the first cycle of a state
  logic [PW-1:0] period_cnt;
  logic [TW-1:0] wdog;
  logic          pending;
  logic          launch;
  logic          done_ok;     // matching done, seen after the start cycle
  logic          abort;
  logic          wd_expired;

  assign wd_expired = (wdog == TW'(TIMEOUT - 1));
  assign busy       = (state != IDLE);
  assign stage      = state;

  // Next-state decode, start pulses and valid pulse; done beats timeout.
  always_comb begin
    state_n       = state;
    cov_start     = 1'b0;
    eig_start     = 1'b0;
    port_start    = 1'b0;
    weights_valid = 1'b0;
    launch        = 1'b0;
    done_ok       = 1'b0;
    abort         = 1'b0;
    case (state)
      IDLE: begin
        if ((period_cnt == PW'(PERIOD - 1)) || force_rebal || pending) begin
          launch  = 1'b1;
          state_n = COV;
        end
      end
      COV: begin
        cov_start = first;
        done_ok   = cov_done && !first;
        if (done_ok)         state_n = EIG;
        else if (wd_expired) abort   = 1'b1;
      end
      EIG: begin
        eig_start = first;
        done_ok   = eig_done && !first;
        if (done_ok)         state_n = PORT;
        else if (wd_expired) abort   = 1'b1;
      end
      PORT: begin
        port_start = first;
        done_ok    = port_done && !first;
        if (done_ok)         state_n = LATCH;
        else if (wd_expired) abort   = 1'b1;
      end
      LATCH: begin
        weights_valid = 1'b1;
        state_n       = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (abort) state_n = IDLE;
  end

  // State, counters, pending request, weight snapshot and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      first       <= 1'b0;
      period_cnt  <= '0;
      wdog        <= '0;
      pending     <= 1'b0;
      weights     <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_n;
      first <= (state_n != state);

      if (state_n != state)
        wdog <= '0;
      else if (state == COV || state == EIG || state == PORT)
        wdog <= wdog + 1'b1;

      if (launch || !enable || state != IDLE)
        period_cnt <= '0;
      else
        period_cnt <= period_cnt + 1'b1;

      if (launch)
        pending <= 1'b0;
      else if (force_rebal && state != IDLE)
        pending <= 1'b1;

      if (state == PORT && done_ok)
        weights <= port_weights;

      if (abort)
        timeout_err <= 1'b1;
      else if (state == PORT && done_ok)
        timeout_err <= 1'b0;
    end
  end

endmodule
